step_dir_bank: RTL and testbench
================================

Name: step_dir_bank

Overview:
Multi-channel memory-mapped step/direction pulse generator on the picorv32 native memory bus. It replaces the single hard-wired test step channel, whose dir lines are tied low. Each channel runs a signed step count at a programmable period, with direction setup time and abort. The block drives the gp step/dir lines directly and sits on the CPU bus beside the existing io registers.

Parameters:
CHANNELS, 12, number of step/dir channel pairs (1..16)
COUNT_WIDTH, 24, magnitude width of the step count; STEPS register is signed COUNT_WIDTH+1 bits
DIV_WIDTH, 16, width of the step period divider in clock cycles
PULSE_WIDTH, 8, step high time in clock cycles (>=1)
DIR_SETUP, 16, cycles from dir_o update to first step_o rise (>=1)
BASE_ADDR, 32'h10000040, byte address of channel 0; 16-byte stride per channel

Ports:
clk_in  input  1  system clock (peripheral_clk domain)
reset_in  input  1  synchronous reset, active-high
mem_valid_i  input  1  CPU bus request valid
mem_instr_i  input  1  instruction fetch flag; fetches are never claimed
mem_addr_i  input  32  byte address
mem_wdata_i  input  32  write data
mem_wstrb_i  input  4  byte strobes; any nonzero = write, zero = read
mem_rdata_o  output  32  read data; 0 whenever mem_ready_o low (OR-combinable)
mem_ready_o  output  1  single-cycle acknowledge
step_o  output  CHANNELS  step pulses, active-high
dir_o  output  CHANNELS  direction (1 = negative count)
busy_o  output  CHANNELS  channel running

Behaviour:
- Reset: all outputs 0. All channel registers 0. FSMs IDLE. Done flags cleared.
- Decode: hit = valid & !instr & BASE_ADDR <= addr < BASE_ADDR+16*CHANNELS. Channel = (addr-BASE_ADDR)>>4. Register = addr[3:2].
- Handshake: on a hit with ready low, ready=1 for exactly the next cycle, then 0 for at least one cycle. Writes commit on the edge that raises ready. rdata is registered on that same edge. A non-hit never raises ready; rdata stays 0.
- Per-channel registers:
  - +0x0 CTRL: write bit0 start, bit1 abort, bit2 clear done. Read bit0 busy, bit1 done (sticky).
  - +0x4 STEPS: rw, signed, sign-extended on read.
  - +0x8 DIV: rw.
  - +0xC REMAIN: ro, remaining magnitude.
- Partial wstrb: bytes with strobe 0 keep their old value. CTRL acts only on byte 0.
- Writes to STEPS/DIV while busy are ignored, but ready is still given. Start while busy is ignored. Start and abort in the same write: abort wins.
- FSM states: IDLE -> SETUP -> HIGH -> LOW -> (HIGH | IDLE).
  - Start in IDLE, STEPS != 0: REMAIN = |STEPS|, dir_o = sign, busy=1, done=0, enter SETUP.
  - SETUP: hold DIR_SETUP cycles; step_o rises on the following edge.
  - HIGH: step_o=1 for PULSE_WIDTH cycles.
  - LOW: step_o=0 for effDIV-PULSE_WIDTH cycles, where effDIV = max(DIV, 2*PULSE_WIDTH). Step period is exactly effDIV cycles.
  - REMAIN decrements on each step_o falling edge. REMAIN reaching 0 at the end of LOW -> IDLE, busy=0, done=1. The last LOW phase is fully timed.
  - Start with STEPS == 0: no pulse, no dir change, done=1 on the commit edge.
- Abort: next state IDLE on the commit edge. step_o=0 and busy=0 on that edge; a truncated high pulse is accepted. REMAIN holds. done is not set. dir_o holds.
- Channels are fully independent. Simultaneous completions on several channels need no arbitration.
- reset_in mid-run: all channels return to reset state on the next edge. A pending ready is dropped.

Test Plan:
- Reset, then read all 4 regs of ch0 and ch11 -> each read acked 1 cycle after valid; rdata=0; step_o/dir_o/busy_o=0.
- PULSE_WIDTH=2, DIR_SETUP=3: ch0 STEPS=3, DIV=10, start -> dir_o=0; first step rise 3 cycles after commit; 3 pulses of 2 high/8 low; done=1, busy=0 after 3rd LOW; REMAIN=0.
- ch5 STEPS=-2, DIV=1 -> dir_o=1; effDIV=4; 2 pulses of 2 high/2 low; STEPS reads 0x...FFFE sign-extended.
- ch2 STEPS=100, DIV=20, abort after 5 falling edges -> step_o low next edge; REMAIN=95; done=0; write STEPS=7 now accepted.
- STEPS=0, start -> done=1, no step_o activity. Read at BASE_ADDR+16*CHANNELS, and a fetch at BASE_ADDR -> no ready, rdata 0.
- ch0 and ch1 started on consecutive writes, reset_in pulsed mid-run -> all outputs and registers 0 next edge; a later start works normally.

Source files
------------

// File: rtl/step_dir_bank_if.sv
// step_dir_bank_if
//   picorv32 native memory bus as seen by the step/dir bank.
//   master : CPU side (drives valid/instr/addr/wdata/wstrb, takes rdata/ready)
//   slave  : peripheral side
//   mem_rdata_o is 0 whenever mem_ready_o is low, so several slaves can be OR-ed.
interface step_dir_bank_if;
    logic        mem_valid_i;
    logic        mem_instr_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;

    modport master (
        output mem_valid_i, mem_instr_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
        input  mem_rdata_o, mem_ready_o
    );

    modport slave (
        input  mem_valid_i, mem_instr_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
        output mem_rdata_o, mem_ready_o
    );
endinterface

// File: rtl/step_dir_bank.sv
// step_dir_bank
//   Bank of CHANNELS independent step/direction pulse generators on the
//   picorv32 native bus. Channel i occupies 16 bytes at BASE_ADDR + 16*i:
//     +0x0 CTRL   (wr: b0 start, b1 abort, b2 clear done; rd: b0 busy, b1 done)
//     +0x4 STEPS  signed step count, sign-extended on read
//     +0x8 DIV    step period in clock cycles (floored at 2*PULSE_WIDTH)
//     +0xC REMAIN remaining step magnitude (read-only)
//   Ports:
//     clk_in, reset_in   clock, synchronous active-high reset
//     bus                slave side of step_dir_bank_if
//     step_o/dir_o/busy_o per-channel step pulse, direction (1 = negative), running

// One step/dir channel: register file plus the IDLE/SETUP/HIGH/LOW sequencer.
module step_dir_chan #(
    parameter int COUNT_WIDTH = 24,
    parameter int DIV_WIDTH   = 16,
    parameter int PULSE_WIDTH = 8,
    parameter int DIR_SETUP   = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rd_data,
    output logic        step,
    output logic        dir,
    output logic        busy
);
    localparam int EW = DIV_WIDTH + 1;
    localparam int SW = $clog2(DIR_SETUP + 1);
    localparam int TW = (EW > SW) ? EW : SW;
    localparam logic [EW-1:0] MIN_DIV = EW'(2 * PULSE_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t                 state;
    logic [COUNT_WIDTH:0]   steps;
    logic [DIV_WIDTH-1:0]   div;
    logic [COUNT_WIDTH-1:0] remain;
    logic                   done;
    logic [TW-1:0]          cnt;

    logic [31:0]            steps_ext, div_ext, remain_ext, steps_new, div_new;
    logic [COUNT_WIDTH:0]   steps_neg;
    logic [EW-1:0]          eff_div, low_len;
    logic                   unused_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = st[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    assign steps_ext  = {{(31-COUNT_WIDTH){steps[COUNT_WIDTH]}}, steps};
    assign div_ext    = {{(32-DIV_WIDTH){1'b0}}, div};
    assign remain_ext = {{(32-COUNT_WIDTH){1'b0}}, remain};
    assign steps_new  = merge(steps_ext, wdata, wstrb);
    assign div_new    = merge(div_ext, wdata, wstrb);
    // The most negative count has magnitude 2^COUNT_WIDTH, which truncates to 0;
    // decrement-on-fall wraps it to all ones, so it still yields 2^COUNT_WIDTH pulses.
    assign steps_neg  = -steps;
    assign eff_div    = ({1'b0, div} > MIN_DIV) ? {1'b0, div} : MIN_DIV;
    assign low_len    = eff_div - EW'(PULSE_WIDTH + 1);
    assign unused_bits = ^{steps_new[31:COUNT_WIDTH+1], div_new[31:DIV_WIDTH], steps_neg[COUNT_WIDTH]};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0: rd_data = {30'b0, done, busy};
            2'd1: rd_data = steps_ext;
            2'd2: rd_data = div_ext;
            default: rd_data = remain_ext;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state  <= IDLE;
            steps  <= '0;
            div    <= '0;
            remain <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            step   <= 1'b0;
            dir    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                SETUP: begin
                    if (cnt == '0) begin
                        state <= HIGH;
                        step  <= 1'b1;
                        cnt   <= TW'(PULSE_WIDTH - 1);
                    end else cnt <= cnt - 1'b1;
                end
                HIGH: begin
                    if (cnt == '0) begin
                        state  <= LOW;
                        step   <= 1'b0;
                        remain <= remain - 1'b1;
                        cnt    <= TW'(low_len);
                    end else cnt <= cnt - 1'b1;
                end
                LOW: begin
                    if (cnt == '0) begin
                        if (remain == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= HIGH;
                            step  <= 1'b1;
                            cnt   <= TW'(PULSE_WIDTH - 1);
                        end
                    end else cnt <= cnt - 1'b1;
                end
                default: ;
            endcase

            // Bus writes come last so they override the sequencer on the same edge.
            if (wr_en) begin
                case (reg_sel)
                    2'd0: if (wstrb[0]) begin
                        if (wdata[1]) begin
                            if (busy) begin
                                state  <= IDLE;
                                step   <= 1'b0;
                                busy   <= 1'b0;
                                remain <= remain;  // cancel a decrement on this edge
                                done   <= done;    // cancel a completion on this edge
                            end
                        end else if (wdata[0] && !busy) begin
                            if (steps == '0) done <= 1'b1;
                            else begin
                                state  <= SETUP;
                                cnt    <= TW'(DIR_SETUP - 1);
                                remain <= steps[COUNT_WIDTH] ? steps_neg[COUNT_WIDTH-1:0]
                                                             : steps[COUNT_WIDTH-1:0];
                                dir    <= steps[COUNT_WIDTH];
                                busy   <= 1'b1;
                                done   <= 1'b0;
                            end
                        end
                        if (wdata[2]) done <= 1'b0;
                    end
                    2'd1: if (!busy) steps <= steps_new[COUNT_WIDTH:0];
                    2'd2: if (!busy) div <= div_new[DIV_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

module step_dir_bank #(
    parameter int          CHANNELS    = 12,
    parameter int          COUNT_WIDTH = 24,
    parameter int          DIV_WIDTH   = 16,
    parameter int          PULSE_WIDTH = 8,
    parameter int          DIR_SETUP   = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h10000040
) (
    input  logic                clk_in,
    input  logic                reset_in,
    step_dir_bank_if.slave      bus,
    output logic [CHANNELS-1:0] step_o,
    output logic [CHANNELS-1:0] dir_o,
    output logic [CHANNELS-1:0] busy_o
);
    localparam logic [31:0] SPAN = 32'(16 * CHANNELS);

    logic [31:0]                offs, rd_sel, rdata_q;
    logic [3:0]                 chan;
    logic                       hit, commit, ready_q;
    logic [CHANNELS-1:0][31:0]  ch_rd;
    logic                       unused_addr;

    assign offs   = bus.mem_addr_i - BASE_ADDR;
    assign hit    = bus.mem_valid_i && !bus.mem_instr_i &&
                    (bus.mem_addr_i >= BASE_ADDR) && (offs < SPAN);
    assign chan   = offs[7:4];
    // A hit is served once; the cycle after ready the request is ignored, which
    // guarantees at least one low cycle between acknowledges.
    assign commit = hit && !ready_q;
    assign unused_addr = ^bus.mem_addr_i[1:0];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        step_dir_chan #(
            .COUNT_WIDTH(COUNT_WIDTH),
            .DIV_WIDTH  (DIV_WIDTH),
            .PULSE_WIDTH(PULSE_WIDTH),
            .DIR_SETUP  (DIR_SETUP)
        ) u_ch (
            .clk_in  (clk_in),
            .reset_in(reset_in),
            .wr_en   (commit && (|bus.mem_wstrb_i) && (chan == 4'(i))),
            .reg_sel (bus.mem_addr_i[3:2]),
            .wdata   (bus.mem_wdata_i),
            .wstrb   (bus.mem_wstrb_i),
            .rd_data (ch_rd[i]),
            .step    (step_o[i]),
            .dir     (dir_o[i]),
            .busy    (busy_o[i])
        );
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < CHANNELS; i++) if (chan == 4'(i)) rd_sel = ch_rd[i];
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else if (commit) begin
            ready_q <= 1'b1;
            rdata_q <= rd_sel;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end
    end

    assign bus.mem_ready_o = ready_q;
    assign bus.mem_rdata_o = rdata_q;
endmodule

// File: tb/tb_step_dir_bank.sv
// tb_step_dir_bank
//   Directed and randomized bus traffic against a timeline model of each
//   channel: a run is described by its commit cycle, pulse count and period,
//   and the expected outputs for any cycle are computed arithmetically.
module tb_step_dir_bank;
    localparam int          CH   = 12;
    localparam int          PW   = 2;
    localparam int          DS   = 3;
    localparam logic [31:0] BASE = 32'h10000040;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] step_o, dir_o, busy_o;

    step_dir_bank_if bus();

    step_dir_bank #(
        .CHANNELS(CH), .COUNT_WIDTH(24), .DIV_WIDTH(16),
        .PULSE_WIDTH(PW), .DIR_SETUP(DS), .BASE_ADDR(BASE)
    ) dut (
        .clk_in(clk), .reset_in(rst), .bus(bus),
        .step_o(step_o), .dir_o(dir_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;
    int last_c0 = 0;

    // model state per channel
    int m_steps[CH];
    int m_div[CH];
    bit m_run[CH];
    int m_c0[CH];
    int m_n[CH];
    int m_e[CH];
    bit m_done[CH];
    bit m_dir[CH];
    int m_rem[CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int end_of(int ch);
        return m_c0[ch] + DS + m_n[ch] * m_e[ch];
    endfunction

    function automatic bit f_busy(int ch, int n);
        return m_run[ch] && n >= m_c0[ch] && n < end_of(ch);
    endfunction

    function automatic bit f_step(int ch, int n);
        int rel;
        rel = n - m_c0[ch] - DS;
        return m_run[ch] && rel >= 0 && rel < m_n[ch] * m_e[ch] && (rel % m_e[ch]) < PW;
    endfunction

    function automatic int f_rem(int ch, int n);
        int rel, falls;
        if (!m_run[ch]) return m_rem[ch];
        rel = n - m_c0[ch] - DS;
        falls = (rel < PW) ? 0 : (rel - PW) / m_e[ch] + 1;
        if (falls > m_n[ch]) falls = m_n[ch];
        return m_n[ch] - falls;
    endfunction

    function automatic bit f_done(int ch, int n);
        return m_run[ch] ? (n >= end_of(ch)) : m_done[ch];
    endfunction

    function automatic logic [31:0] m_read(int ch, int rg, int n);
        case (rg)
            0: return {30'b0, f_done(ch, n), f_busy(ch, n)};
            1: return 32'(m_steps[ch]);
            2: return 32'(m_div[ch]);
            default: return 32'(f_rem(ch, n));
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = st[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    task automatic settle(int ch, int n);
        if (m_run[ch] && n >= end_of(ch)) begin
            m_run[ch]  = 1'b0;
            m_done[ch] = 1'b1;
            m_rem[ch]  = 0;
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_steps[c] = 0; m_div[c] = 0; m_run[c] = 0; m_c0[c] = 0; m_n[c] = 0;
            m_e[c] = 1; m_done[c] = 0; m_dir[c] = 0; m_rem[c] = 0;
        end
    endtask

    // apply a write committed on edge c0 (pre-edge state is at c0-1)
    task automatic m_write(int ch, int rg, logic [31:0] wd, logic [3:0] st, int c0);
        bit bp;
        logic [31:0] m;
        logic [24:0] t;
        bp = f_busy(ch, c0 - 1);
        if (rg == 0 && st[0] && wd[1] && bp) begin
            m_rem[ch] = f_rem(ch, c0 - 1);
            m_run[ch] = 1'b0;
        end else settle(ch, c0);
        case (rg)
            0: if (st[0]) begin
                if (!wd[1] && wd[0] && !bp) begin
                    if (m_steps[ch] == 0) m_done[ch] = 1'b1;
                    else begin
                        m_run[ch]  = 1'b1;
                        m_c0[ch]   = c0;
                        m_n[ch]    = (m_steps[ch] < 0) ? -m_steps[ch] : m_steps[ch];
                        m_e[ch]    = (m_div[ch] > 2 * PW) ? m_div[ch] : 2 * PW;
                        m_dir[ch]  = m_steps[ch] < 0;
                        m_done[ch] = 1'b0;
                    end
                end
                if (wd[2]) m_done[ch] = 1'b0;
            end
            1: if (!bp) begin
                m = merge(32'(m_steps[ch]), wd, st);
                t = m[24:0];
                m_steps[ch] = int'($signed(t));
            end
            2: if (!bp) begin
                m = merge(32'(m_div[ch]), wd, st);
                m_div[ch] = int'(m[15:0]);
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin : cmp_p
        logic [CH-1:0] es, ed, eb;
        if (chk_en) begin
            for (int c = 0; c < CH; c++) begin
                es[c] = f_step(c, cyc);
                ed[c] = m_dir[c];
                eb[c] = f_busy(c, cyc);
            end
            check("step_o", 32'(step_o), 32'(es));
            check("dir_o", 32'(dir_o), 32'(ed));
            check("busy_o", 32'(busy_o), 32'(eb));
            if (!bus.mem_ready_o) check("rdata_idle", bus.mem_rdata_o, 32'h0);
        end
    end

    task automatic bus_op(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                          input bit instr, output logic [31:0] rd);
        bit hit;
        int ch, rg;
        hit = !instr && addr >= BASE && addr < BASE + 32'(16 * CH);
        ch  = int'((addr - BASE) >> 4);
        rg  = int'(addr[3:2]);
        @(negedge clk);
        bus.mem_valid_i = 1'b1;
        bus.mem_instr_i = instr;
        bus.mem_addr_i  = addr;
        bus.mem_wdata_i = wd;
        bus.mem_wstrb_i = st;
        @(posedge clk); #1;
        rd = bus.mem_rdata_o;
        if (hit) begin
            last_c0 = cyc;
            check("ready_ack", 32'(bus.mem_ready_o), 32'h1);
            if (st == 4'h0) check($sformatf("rdata ch%0d r%0d", ch, rg), rd, m_read(ch, rg, cyc - 1));
            else m_write(ch, rg, wd, st, cyc);
        end else begin
            check("miss_ready", 32'(bus.mem_ready_o), 32'h0);
            check("miss_rdata", rd, 32'h0);
        end
        bus.mem_valid_i = 1'b0;
        bus.mem_instr_i = 1'b0;
        bus.mem_wstrb_i = 4'h0;
        @(posedge clk); #1;
        check("ready_drop", 32'(bus.mem_ready_o), 32'h0);
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] v, input logic [3:0] st);
        logic [31:0] d;
        bus_op(BASE + 32'(16 * ch + 4 * rg), v, st, 1'b0, d);
    endtask

    task automatic rd(input int ch, input int rg, output logic [31:0] v);
        bus_op(BASE + 32'(16 * ch + 4 * rg), 32'h0, 4'h0, 1'b0, v);
    endtask

    // follow a run until busy drops; report first rise, end cycle, pulse count
    task automatic watch(input int ch, output int first, output int endc, output int pulses);
        bit prev;
        prev = 1'b0; pulses = 0; first = -1;
        for (int k = 0; k < 5000; k++) begin
            if (step_o[ch] && !prev) begin
                pulses++;
                if (first < 0) first = cyc;
            end
            prev = step_o[ch];
            if (!busy_o[ch]) break;
            @(posedge clk); #1;
        end
        endc = cyc;
    endtask

    initial begin : main
        logic [31:0] v;
        int c0, first, endc, pulses, falls;
        bit prev;
        bus.mem_valid_i = 1'b0; bus.mem_instr_i = 1'b0; bus.mem_addr_i = '0;
        bus.mem_wdata_i = '0;   bus.mem_wstrb_i = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        check("rst_step", 32'(step_o), 32'h0);
        check("rst_dir", 32'(dir_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        for (int r = 0; r < 4; r++) begin
            rd(0, r, v);  check("rst_rd_ch0", v, 32'h0);
            rd(11, r, v); check("rst_rd_ch11", v, 32'h0);
        end

        // ch0: 3 steps, period 10
        wr(0, 1, 32'd3, 4'hF);
        wr(0, 2, 32'd10, 4'hF);
        wr(0, 0, 32'h1, 4'h1);
        c0 = last_c0;
        check("ch0_dir", 32'(dir_o[0]), 32'h0);
        watch(0, first, endc, pulses);
        check("ch0_first_rise", 32'(first - c0), 32'd3);
        check("ch0_pulses", 32'(pulses), 32'd3);
        check("ch0_done_cycle", 32'(endc - c0), 32'd33);
        rd(0, 3, v); check("ch0_remain", v, 32'h0);
        rd(0, 0, v); check("ch0_ctrl", v, 32'h2);

        // ch5: -2 steps, DIV below floor
        wr(5, 1, 32'hFFFFFFFE, 4'hF);
        wr(5, 2, 32'd1, 4'hF);
        rd(5, 1, v); check("ch5_steps_sext", v, 32'hFFFFFFFE);
        wr(5, 0, 32'h1, 4'h1);
        c0 = last_c0;
        check("ch5_dir", 32'(dir_o[5]), 32'h1);
        watch(5, first, endc, pulses);
        check("ch5_pulses", 32'(pulses), 32'd2);
        check("ch5_done_cycle", 32'(endc - c0), 32'd11);

        // ch2: abort after 5 falling edges
        wr(2, 1, 32'd100, 4'hF);
        wr(2, 2, 32'd20, 4'hF);
        wr(2, 0, 32'h1, 4'h1);
        falls = 0; prev = 1'b0;
        for (int k = 0; k < 3000 && falls < 5; k++) begin
            @(posedge clk); #1;
            if (prev && !step_o[2]) falls++;
            prev = step_o[2];
        end
        check("ch2_falls", 32'(falls), 32'd5);
        wr(2, 1, 32'd9, 4'hF);            // ignored: channel busy
        wr(2, 0, 32'h2, 4'h1);
        check("ch2_abort_step", 32'(step_o[2]), 32'h0);
        check("ch2_abort_busy", 32'(busy_o[2]), 32'h0);
        rd(2, 3, v); check("ch2_remain", v, 32'd95);
        rd(2, 0, v); check("ch2_ctrl", v, 32'h0);
        rd(2, 1, v); check("ch2_steps_kept", v, 32'd100);
        wr(2, 1, 32'd7, 4'hF);
        rd(2, 1, v); check("ch2_steps_new", v, 32'd7);

        // zero-step start, out-of-range read, instruction fetch
        wr(3, 0, 32'h1, 4'h1);
        rd(3, 0, v); check("ch3_zero_done", v, 32'h2);
        bus_op(BASE + 32'(16 * CH), 32'h0, 4'h0, 1'b0, v);
        bus_op(BASE, 32'h0, 4'h0, 1'b1, v);

        // reset mid-run
        wr(0, 1, 32'd5, 4'hF);
        wr(0, 2, 32'd6, 4'hF);
        wr(0, 0, 32'h1, 4'h1);
        wr(1, 1, 32'hFFFFFFFC, 4'hF);
        wr(1, 0, 32'h1, 4'h1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        m_reset();
        check("mid_rst_busy", 32'(busy_o), 32'h0);
        check("mid_rst_dir", 32'(dir_o), 32'h0);
        check("mid_rst_step", 32'(step_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(0, 1, v); check("mid_rst_steps", v, 32'h0);
        rd(1, 0, v); check("mid_rst_ctrl", v, 32'h0);
        wr(0, 1, 32'd2, 4'hF);
        wr(0, 0, 32'h1, 4'h1);
        c0 = last_c0;
        watch(0, first, endc, pulses);
        check("post_rst_pulses", 32'(pulses), 32'd2);
        check("post_rst_done_cycle", 32'(endc - c0), 32'd11);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            int ch, op, sv;
            logic [3:0] st;
            ch = $urandom_range(0, CH - 1);
            op = $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0: st = 4'h1;
                1: st = 4'hE;
                default: st = 4'hF;
            endcase
            case (op)
                0, 1: rd(ch, $urandom_range(0, 3), v);
                2: begin
                    sv = $urandom_range(0, 12) - 6;
                    wr(ch, 1, 32'(sv), st);
                end
                3: wr(ch, 2, 32'($urandom_range(0, 12)), ($urandom_range(0, 1) != 0) ? 4'h1 : 4'hF);
                4: wr(ch, 0, 32'h1, 4'h1);
                default: wr(ch, 0, 32'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0) ? 4'h2 : 4'hF);
            endcase
            repeat ($urandom_range(0, 25)) @(posedge clk);
        end

        // drain
        for (int k = 0; k < 20000 && busy_o != '0; k++) @(posedge clk);
        @(negedge clk);
        check("drain_idle", 32'(busy_o), 32'h0);
        for (int c = 0; c < CH; c++) begin
            rd(c, 0, v);
            rd(c, 3, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
